// File: rtl/chunked_addsub_pkg.sv
// chunked_addsub_pkg: shared state encoding, opcode values and sizing helper
package chunked_addsub_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/chunked_addsub_if.sv
// chunked_addsub_if: request/result bundle of the chunked adder/subtractor
//   master drives start/op_sub/A/B/Cin and observes busy/done/Sum/Cout/Ovf/Zero/Neg
//   slave is the datapath side
interface chunked_addsub_if #(parameter int N = 32);

    logic         start;
    logic         op_sub;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Cin;
    logic         busy;
    logic         done;
    logic [N-1:0] Sum;
    logic         Cout;
    logic         Ovf;
    logic         Zero;
    logic         Neg;

    modport master (output start, op_sub, A, B, Cin,
                    input  busy, done, Sum, Cout, Ovf, Zero, Neg);
    modport slave  (input  start, op_sub, A, B, Cin,
                    output busy, done, Sum, Cout, Ovf, Zero, Neg);

endinterface

// File: rtl/chunked_addsub_chunk_rca.sv
// chunk_rca: combinational W-bit ripple-carry adder slice
//   a, b  : addends          cin  : carry in
//   sum   : W-bit result     cout : carry out of bit W-1
//   cmsb  : carry into bit W-1 (for signed overflow detection)
module chunk_rca #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         cmsb
);

    logic [W:0] w_c;

    always_comb begin
        w_c    = '0;
        sum    = '0;
        w_c[0] = cin;
        for (int i = 0; i < W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ w_c[i];
            w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = w_c[W];
    assign cmsb = w_c[W-1];

endmodule

// File: rtl/chunked_addsub.sv
// chunked_addsub: multi-cycle N-bit add/sub computed W bits per clock, LSB chunk first
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of chunked_addsub_if (start/op_sub/A/B/Cin in,
//           busy/done/Sum/Cout/Ovf/Zero/Neg out)
module chunked_addsub
    import chunked_addsub_pkg::*;
#(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    chunked_addsub_if.slave    bus
);

    localparam int K  = N / W;
    localparam int CW = (clog2(K) > 1) ? clog2(K) : 1;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic           r_c;
    logic [N-1:0]   r_shadow;
    logic           r_busy;
    logic           r_done;
    logic [N-1:0]   r_sum;
    logic           r_cout;
    logic           r_ovf;
    logic           r_zero;
    logic           r_neg;

    logic [31:0]    w_base;
    logic [W-1:0]   w_sum;
    logic           w_cout;
    logic           w_cmsb;
    logic [N-1:0]   w_full;

    assign w_base = 32'(r_cnt) * 32'(W);

    chunk_rca #(.W(W)) u_rca (
        .a    (r_a[w_base +: W]),
        .b    (r_b[w_base +: W]),
        .cin  (r_c),
        .sum  (w_sum),
        .cout (w_cout),
        .cmsb (w_cmsb)
    );

    // Shadow with the current chunk merged in; on the last chunk this is the full result.
    always_comb begin
        w_full = r_shadow;
        w_full[w_base +: W] = w_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= 1'b0;
            r_shadow <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (bus.start) begin
                    r_a     <= bus.A;
                    // Subtraction is A + ~B + 1, so B is inverted once at latch time.
                    r_b     <= (bus.op_sub == OP_SUB) ? ~bus.B : bus.B;
                    r_c     <= (bus.op_sub == OP_ADD) ? bus.Cin : 1'b1;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                    r_state <= RUN;
                end
            end else begin
                r_shadow <= w_full;
                r_c      <= w_cout;
                r_cnt    <= r_cnt + CW'(1);
                if (r_cnt == CW'(K - 1)) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_sum   <= w_full;
                    r_cout  <= w_cout;
                    r_ovf   <= w_cmsb ^ w_cout;
                    r_zero  <= (w_full == '0);
                    r_neg   <= w_full[N-1];
                end
            end
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.Sum  = r_sum;
    assign bus.Cout = r_cout;
    assign bus.Ovf  = r_ovf;
    assign bus.Zero = r_zero;
    assign bus.Neg  = r_neg;

endmodule
